ppu_pixel_mux: RTL and testbench
================================

PPU_PIXEL_MUX -- requirements
Module: ppu_pixel_mux

Interface
REQ-001 SHALL have port clk_in, input, 1, system clock; all logic rises on clk_in.
REQ-002 SHALL have port rst_in, input, 1, reset; asynchronous, active-high.
REQ-003 SHALL have port nes_pix_pulse, input, 1, pixel-advance enable, one clk_in cycle wide.
REQ-004 SHALL have ports nes_x_in and nes_y_in, inputs, 10 each, current dot and scanline.
REQ-005 SHALL have port bg_pal_in, input, 4, background palette index from the background fetch stage.
REQ-006 SHALL have port spr_pal_in, input, 4, sprite palette index.
REQ-007 SHALL have ports spr_pri_in and spr_zero_in, inputs, 1 each: spr_pri_in=1 places the sprite behind background; spr_zero_in=1 marks the pixel as coming from sprite 0.
REQ-008 SHALL have ports en_bg, en_bg_left, en_spr, en_spr_left and grayscale_in, inputs, 1 each, PPUMASK controls.
REQ-009 SHALL have CPU palette port inputs pal_addr_in (5), pal_data_in (6), pal_wr_in (1) and pal_rd_in (1).
REQ-010 SHALL have port pal_data_out, output, 6, CPU palette read data.
REQ-011 SHALL have ports color_out (output, 6, NES master colour) and color_valid_out (output, 1, marks a visible pixel).
REQ-012 SHALL have port spr0_hit_out, output, 1, sprite-0 hit flag for PPUSTATUS bit 6.

Function
REQ-013 SHALL define a pixel as visible when nes_x_in < 256 and nes_y_in < 240.
REQ-014 SHALL compute effective bg = (en_bg and (x >= 8 or en_bg_left)) ? bg_pal_in : 0, and effective spr the same way using en_spr and en_spr_left.
REQ-015 SHALL treat a pixel as opaque when index[1:0] != 0.
REQ-016 SHALL select the palette address as follows: both transparent -> 0x00; bg only -> {0,bg}; spr only -> {1,spr}; both opaque -> spr_pri_in ? {0,bg} : {1,spr}.
REQ-017 SHALL mirror every palette address with addr[1:0]=0 and addr[4]=1 to addr[4]=0 (0x10/14/18/1C -> 0x00/04/08/0C), on both the CPU and pixel paths.
REQ-018 SHALL run a 2-stage pipeline advanced only on nes_pix_pulse: stage 1 registers the address and visibility; stage 2 reads RAM into color_out; latency is exactly 2 pixel pulses.
REQ-019 SHALL drive color_out = ram & 6'h30 when grayscale_in is 1, sampled in stage 2.
REQ-020 SHALL drive color_valid_out=0 and color_out=6'h0F (black) for non-visible pixels, with the same 2-pulse latency.
REQ-021 SHALL set spr0_hit_out when all of the following hold: visible, spr_zero_in, both effective pixels opaque, en_bg and en_spr both 1, and x != 255; it sets in the stage-1 cycle and is sticky.
REQ-022 SHALL clear spr0_hit_out on the pixel pulse where y==261 and x==1; clear wins over a simultaneous set.
REQ-023 SHALL accept pal_wr_in on any clk_in cycle, independent of nes_pix_pulse, writing pal_data_in to the mirrored address.
REQ-024 SHALL make the pixel read return the old data when a CPU write hits the same address in the same cycle (read-first).
REQ-025 SHALL register pal_data_out on the clk_in cycle after pal_rd_in; pal_data_out holds its value otherwise.
REQ-026 SHALL hold all state when nes_pix_pulse=0, except the CPU port.

Reset
REQ-027 SHALL, while rst_in=1, drive color_out=0x0F, color_valid_out=0, spr0_hit_out=0 and pal_data_out=0, clear both pipeline stages, and clear all 32 palette entries to 0.
REQ-028 SHALL treat reset asserted mid-frame as discarding in-flight pixels; the first valid output after release follows the 2-pulse latency.

Structure
REQ-029 SHALL place the constants VIS_W=256, VIS_H=240, PRERENDER_LINE=261, COLOR_BLANK=6'h0F and the palette mirror function in the shared package ppu_pkg.
REQ-030 SHALL implement the 32x6 palette storage, with one write port and two read ports, as sub-module ppu_palette_ram.

Verification
REQ-031 SHALL cover: write 0x21 to 0x00 and 0x15 to 0x05; bg=5, spr=0 at x=20,y=10 -> color_out=0x15, valid=1, two pulses later.
REQ-032 SHALL cover: write 0x2A to 0x10, then CPU read 0x00 -> pal_data_out=0x2A; a pixel with both transparent -> color_out=0x2A.
REQ-033 SHALL cover: bg=1, spr=2, spr_pri=1 -> color_out=RAM[0x01]; with spr_pri=0 -> RAM[0x12].
REQ-034 SHALL cover: sprite 0 at x=4 with en_bg_left=0 -> no hit; at x=100 -> hit=1, holds until y=261,x=1, then 0.
REQ-035 SHALL cover: hit condition at x=255 -> no hit; grayscale_in=1 with RAM=0x27 -> color_out=0x20.
REQ-036 SHALL cover: same-cycle CPU write 0x30 and pixel read of 0x03 (old value 0x11) -> color_out=0x11; the next read returns 0x30.

Source files
------------

// File: rtl/ppu_pkg.sv
// Shared PPU constants and the palette address mirror used by the pixel mux.
package ppu_pkg;

  localparam int unsigned VIS_W          = 256;
  localparam int unsigned VIS_H          = 240;
  localparam int unsigned PRERENDER_LINE = 261;
  localparam int unsigned COORD_W        = 10;
  localparam int unsigned PAL_AW         = 5;
  localparam int unsigned PAL_DEPTH      = 32;
  localparam int unsigned COLOR_W        = 6;
  localparam int unsigned IDX_W          = 4;

  localparam logic [COLOR_W-1:0] COLOR_BLANK = 6'h0F;
  localparam logic [COLOR_W-1:0] GRAY_MASK   = 6'h30;

  // Sprite backdrop entries 0x10/14/18/1C alias the background entries.
  function automatic logic [PAL_AW-1:0] pal_mirror(input logic [PAL_AW-1:0] addr);
    return (addr[1:0] == 2'b00) ? {1'b0, addr[3:0]} : addr;
  endfunction

endpackage

// File: rtl/ppu_pixel_mux_if.sv
// CPU-side palette access bus of the pixel mux.
interface ppu_pixel_mux_if;
  import ppu_pkg::*;

  logic [PAL_AW-1:0]  pal_addr_in;
  logic [COLOR_W-1:0] pal_data_in;
  logic               pal_wr_in;
  logic               pal_rd_in;
  logic [COLOR_W-1:0] pal_data_out;

  modport master (
    output pal_addr_in, pal_data_in, pal_wr_in, pal_rd_in,
    input  pal_data_out
  );

  modport slave (
    input  pal_addr_in, pal_data_in, pal_wr_in, pal_rd_in,
    output pal_data_out
  );
endinterface

// File: rtl/ppu_palette_ram.sv
// 32x6 palette storage: one synchronous write port, two asynchronous read ports.
module ppu_palette_ram
  import ppu_pkg::*;
(
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               i_wr_en,
  input  logic [PAL_AW-1:0]  i_wr_addr,
  input  logic [COLOR_W-1:0] i_wr_data,
  input  logic [PAL_AW-1:0]  i_rd_a_addr,
  output logic [COLOR_W-1:0] o_rd_a_data,
  input  logic [PAL_AW-1:0]  i_rd_b_addr,
  output logic [COLOR_W-1:0] o_rd_b_data
);

  logic [COLOR_W-1:0] r_mem [PAL_DEPTH];

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_mem <= '{default: '0};
    end else if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Readers register these at the same edge as a write, so they see old data.
  assign o_rd_a_data = r_mem[i_rd_a_addr];
  assign o_rd_b_data = r_mem[i_rd_b_addr];

endmodule

// File: rtl/ppu_pixel_mux.sv
// Background/sprite priority mux, palette lookup pipeline and sprite-0 hit detection.
module ppu_pixel_mux
  import ppu_pkg::*;
(
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               nes_pix_pulse,
  input  logic [COORD_W-1:0] nes_x_in,
  input  logic [COORD_W-1:0] nes_y_in,
  input  logic [IDX_W-1:0]   bg_pal_in,
  input  logic [IDX_W-1:0]   spr_pal_in,
  input  logic               spr_pri_in,
  input  logic               spr_zero_in,
  input  logic               en_bg,
  input  logic               en_bg_left,
  input  logic               en_spr,
  input  logic               en_spr_left,
  input  logic               grayscale_in,
  ppu_pixel_mux_if.slave     cpu,
  output logic [COLOR_W-1:0] color_out,
  output logic               color_valid_out,
  output logic               spr0_hit_out
);

  logic               w_visible;
  logic               w_left_ok;
  logic [IDX_W-1:0]   w_bg_eff;
  logic [IDX_W-1:0]   w_spr_eff;
  logic               w_bg_opq;
  logic               w_spr_opq;
  logic [PAL_AW-1:0]  w_pix_addr;
  logic               w_hit_set;
  logic               w_hit_clr;
  logic [PAL_AW-1:0]  w_cpu_addr;
  logic [COLOR_W-1:0] w_pix_data;
  logic [COLOR_W-1:0] w_cpu_data;

  logic [PAL_AW-1:0]  r_s1_addr;
  logic               r_s1_vis;

  assign w_visible = (nes_x_in < COORD_W'(VIS_W)) && (nes_y_in < COORD_W'(VIS_H));
  assign w_left_ok = (nes_x_in >= COORD_W'(8));
  assign w_bg_eff  = (en_bg  && (w_left_ok || en_bg_left))  ? bg_pal_in  : IDX_W'(0);
  assign w_spr_eff = (en_spr && (w_left_ok || en_spr_left)) ? spr_pal_in : IDX_W'(0);
  assign w_bg_opq  = |w_bg_eff[1:0];
  assign w_spr_opq = |w_spr_eff[1:0];

  // Priority select between background and sprite palettes.
  always_comb begin
    w_pix_addr = '0;
    case ({w_spr_opq, w_bg_opq})
      2'b01:   w_pix_addr = {1'b0, w_bg_eff};
      2'b10:   w_pix_addr = {1'b1, w_spr_eff};
      2'b11:   w_pix_addr = spr_pri_in ? {1'b0, w_bg_eff} : {1'b1, w_spr_eff};
      default: w_pix_addr = '0;
    endcase
  end

  assign w_hit_set = w_visible && spr_zero_in && w_bg_opq && w_spr_opq &&
                     en_bg && en_spr && (nes_x_in != COORD_W'(255));
  assign w_hit_clr = (nes_y_in == COORD_W'(PRERENDER_LINE)) && (nes_x_in == COORD_W'(1));

  assign w_cpu_addr = pal_mirror(cpu.pal_addr_in);

  ppu_palette_ram u_ram (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .i_wr_en     (cpu.pal_wr_in),
    .i_wr_addr   (w_cpu_addr),
    .i_wr_data   (cpu.pal_data_in),
    .i_rd_a_addr (r_s1_addr),
    .o_rd_a_data (w_pix_data),
    .i_rd_b_addr (w_cpu_addr),
    .o_rd_b_data (w_cpu_data)
  );

  // Pixel pipeline and sprite-0 flag, advanced only by the pixel pulse.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_s1_addr       <= '0;
      r_s1_vis        <= 1'b0;
      color_out       <= COLOR_BLANK;
      color_valid_out <= 1'b0;
      spr0_hit_out    <= 1'b0;
    end else if (nes_pix_pulse) begin
      r_s1_addr       <= pal_mirror(w_pix_addr);
      r_s1_vis        <= w_visible;
      color_valid_out <= r_s1_vis;
      if (!r_s1_vis) begin
        color_out <= COLOR_BLANK;
      end else if (grayscale_in) begin
        color_out <= w_pix_data & GRAY_MASK;
      end else begin
        color_out <= w_pix_data;
      end
      if (w_hit_clr) begin
        spr0_hit_out <= 1'b0;
      end else if (w_hit_set) begin
        spr0_hit_out <= 1'b1;
      end
    end
  end

  // CPU read port runs every clock regardless of the pixel pulse.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cpu.pal_data_out <= '0;
    end else if (cpu.pal_rd_in) begin
      cpu.pal_data_out <= w_cpu_data;
    end
  end

endmodule

// File: tb/tb_ppu_pixel_mux.sv
// Directed and randomized checks of ppu_pixel_mux against a behavioural model.
module tb_ppu_pixel_mux;
  import ppu_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       pulse;
  logic [9:0] x, y;
  logic [3:0] bg, spr;
  logic       pri, zero, ebg, ebgl, espr, esprl, gray;
  logic [5:0] color;
  logic       valid, hit;

  always #5 clk = ~clk;

  ppu_pixel_mux_if bus ();

  ppu_pixel_mux dut (
    .clk_in          (clk),
    .rst_in          (rst),
    .nes_pix_pulse   (pulse),
    .nes_x_in        (x),
    .nes_y_in        (y),
    .bg_pal_in       (bg),
    .spr_pal_in      (spr),
    .spr_pri_in      (pri),
    .spr_zero_in     (zero),
    .en_bg           (ebg),
    .en_bg_left      (ebgl),
    .en_spr          (espr),
    .en_spr_left     (esprl),
    .grayscale_in    (gray),
    .cpu             (bus.slave),
    .color_out       (color),
    .color_valid_out (valid),
    .spr0_hit_out    (hit)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  int         m_pal [32];
  int         m_s1_addr;
  bit         m_s1_vis;
  logic [5:0] m_color;
  bit         m_valid;
  bit         m_hit;
  logic [5:0] m_rd;

  function automatic int mir(input int a);
    return (a % 4 == 0) ? (a % 16) : a;
  endfunction

  function automatic int eff_bg();
    return (ebg && (int'(x) >= 8 || ebgl)) ? int'(bg) : 0;
  endfunction

  function automatic int eff_spr();
    return (espr && (int'(x) >= 8 || esprl)) ? int'(spr) : 0;
  endfunction

  function automatic int ref_addr();
    int b, s, a;
    bit bo, so;
    b = eff_bg(); s = eff_spr();
    bo = (b % 4) != 0; so = (s % 4) != 0;
    if (!bo && !so)     a = 0;
    else if (bo && !so) a = b;
    else if (!bo)       a = 16 + s;
    else                a = pri ? b : 16 + s;
    return mir(a);
  endfunction

  function automatic bit ref_vis();
    return (int'(x) < 256) && (int'(y) < 240);
  endfunction

  function automatic bit hit_cond();
    return ref_vis() && zero && (eff_bg() % 4 != 0) && (eff_spr() % 4 != 0) &&
           ebg && espr && (int'(x) != 255);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_pal[i] = 0;
    m_s1_addr = 0; m_s1_vis = 0;
    m_color = 6'h0F; m_valid = 0; m_hit = 0; m_rd = 6'h00;
  endtask

  task automatic chk(input string tag, input logic [5:0] got, input logic [5:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_color"}, color, m_color);
    chk({tag, "_valid"}, {5'b0, valid}, {5'b0, m_valid});
    chk({tag, "_hit"}, {5'b0, hit}, {5'b0, m_hit});
    chk({tag, "_rd"}, bus.pal_data_out, m_rd);
  endtask

  // One clk cycle starting and ending at a falling edge; model updated read-first.
  task automatic tick(input bit p, input bit wr, input bit rd,
                      input logic [4:0] addr, input logic [5:0] data);
    int ma;
    pulse = p;
    bus.pal_wr_in = wr; bus.pal_rd_in = rd;
    bus.pal_addr_in = addr; bus.pal_data_in = data;
    @(posedge clk);
    ma = mir(int'(addr));
    if (rd) m_rd = 6'(m_pal[ma]);
    if (p) begin
      if (m_s1_vis) begin
        m_color = gray ? (6'(m_pal[m_s1_addr]) & 6'h30) : 6'(m_pal[m_s1_addr]);
        m_valid = 1;
      end else begin
        m_color = 6'h0F;
        m_valid = 0;
      end
      m_s1_addr = ref_addr();
      m_s1_vis  = ref_vis();
      if (int'(y) == 261 && int'(x) == 1) m_hit = 0;
      else if (hit_cond())                m_hit = 1;
    end
    if (wr) m_pal[ma] = int'(data);
    @(negedge clk);
    pulse = 0; bus.pal_wr_in = 0; bus.pal_rd_in = 0;
  endtask

  task automatic wr_pal(input logic [4:0] a, input logic [5:0] d);
    tick(0, 1, 0, a, d);
  endtask

  task automatic rd_pal(input logic [4:0] a);
    tick(0, 0, 1, a, 6'h00);
  endtask

  task automatic set_pix(input int px, input int py, input int pbg, input int pspr,
                         input bit ppri, input bit pzero);
    x = 10'(px); y = 10'(py); bg = 4'(pbg); spr = 4'(pspr); pri = ppri; zero = pzero;
  endtask

  task automatic pix();
    tick(1, 0, 0, 5'h00, 6'h00);
    tick(0, 0, 0, 5'h00, 6'h00);
  endtask

  initial begin
    rst = 1; pulse = 0;
    x = 0; y = 0; bg = 0; spr = 0; pri = 0; zero = 0;
    ebg = 1; ebgl = 1; espr = 1; esprl = 1; gray = 0;
    bus.pal_addr_in = 0; bus.pal_data_in = 0; bus.pal_wr_in = 0; bus.pal_rd_in = 0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_color", color, 6'h0F);
    chk("rst_valid", {5'b0, valid}, 6'h00);
    chk("rst_hit", {5'b0, hit}, 6'h00);
    chk("rst_rd", bus.pal_data_out, 6'h00);
    rst = 0;
    @(negedge clk);

    // Basic background lookup with two-pulse latency
    wr_pal(5'h00, 6'h21);
    wr_pal(5'h05, 6'h15);
    set_pix(20, 10, 5, 0, 0, 0); pix();
    chk("lat1_valid", {5'b0, valid}, 6'h00);
    set_pix(21, 10, 5, 0, 0, 0); pix();
    chk("bg_color", color, 6'h15);
    chk("bg_valid", {5'b0, valid}, 6'h01);
    chk_model("bg");

    // Mirrored write to 0x10, CPU read and backdrop pixel
    wr_pal(5'h10, 6'h2A);
    rd_pal(5'h00);
    chk("mirror_rd", bus.pal_data_out, 6'h2A);
    repeat (2) tick(0, 0, 0, 5'h00, 6'h00);
    chk("rd_hold", bus.pal_data_out, 6'h2A);
    set_pix(30, 10, 0, 0, 0, 0); pix(); pix();
    chk("backdrop", color, 6'h2A);

    // Priority
    wr_pal(5'h01, 6'h05);
    wr_pal(5'h12, 6'h16);
    set_pix(40, 10, 1, 2, 1, 0); pix();
    set_pix(41, 10, 1, 2, 0, 0); pix();
    chk("pri_behind", color, 6'h05);
    pix();
    chk("pri_front", color, 6'h16);
    chk_model("pri");

    // Sprite-0 hit: left clip, set, sticky, clear
    ebgl = 0;
    set_pix(4, 20, 1, 1, 0, 1); pix();
    chk("hit_clip", {5'b0, hit}, 6'h00);
    set_pix(100, 20, 1, 1, 0, 1); pix();
    chk("hit_set", {5'b0, hit}, 6'h01);
    set_pix(101, 21, 0, 0, 0, 0); pix();
    chk("hit_sticky", {5'b0, hit}, 6'h01);
    set_pix(1, 261, 1, 1, 0, 1); pix();
    chk("hit_clear", {5'b0, hit}, 6'h00);
    ebgl = 1;
    set_pix(255, 30, 1, 1, 0, 1); pix();
    chk("hit_x255", {5'b0, hit}, 6'h00);

    // Grayscale
    wr_pal(5'h06, 6'h27);
    gray = 1;
    set_pix(50, 30, 6, 0, 0, 0); pix(); pix();
    chk("gray", color, 6'h20);
    gray = 0;

    // Same-cycle CPU write and pixel read of the same entry
    wr_pal(5'h03, 6'h11);
    set_pix(60, 30, 3, 0, 0, 0); pix();
    set_pix(61, 30, 3, 0, 0, 0);
    tick(1, 1, 0, 5'h03, 6'h30);
    chk("rdfirst_old", color, 6'h11);
    pix();
    chk("rdfirst_new", color, 6'h30);

    // Non-visible pixel
    set_pix(300, 10, 3, 0, 0, 0); pix(); pix();
    chk("invis_color", color, 6'h0F);
    chk("invis_valid", {5'b0, valid}, 6'h00);

    // Reset mid-frame discards in-flight pixels and clears the palette
    set_pix(70, 40, 3, 0, 0, 0); pix();
    rst = 1; model_reset();
    #1;
    chk("mrst_color", color, 6'h0F);
    chk("mrst_valid", {5'b0, valid}, 6'h00);
    @(negedge clk); rst = 0;
    pix();
    chk("mrst_lat1", {5'b0, valid}, 6'h00);
    pix();
    chk("mrst_color2", color, 6'h00);
    chk("mrst_valid2", {5'b0, valid}, 6'h01);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      int sel;
      ebg = 1'($urandom); espr = 1'($urandom);
      ebgl = 1'($urandom); esprl = 1'($urandom);
      gray = ($urandom_range(0, 7) == 0);
      sel = int'($urandom_range(0, 4));
      case (sel)
        0: x = 10'($urandom_range(0, 9));
        1: x = 10'($urandom_range(250, 259));
        2: x = 10'd1;
        default: x = 10'($urandom_range(0, 340));
      endcase
      y = ($urandom_range(0, 9) == 0) ? 10'd261 : 10'($urandom_range(0, 261));
      bg = 4'($urandom); spr = 4'($urandom);
      pri = 1'($urandom); zero = ($urandom_range(0, 2) == 0);
      tick(1'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
           5'($urandom), 6'($urandom));
      chk_model("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
